ysyx_24120013_imem_responder: RTL and testbench

//   Instruction-memory responder: the memory end of the core's fetch path. Accepts a PC
//   on a valid/ready request channel, waits LATENCY cycles, returns the 32-bit word on a

---
 rtl/ysyx_24120013_imem_pkg.sv | 14 +
 rtl/ysyx_24120013_imem_array.sv | 29 ++
 rtl/ysyx_24120013_imem.sv | 115 +++++++++++
 tb/tb_ysyx_24120013_imem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24120013_imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional fetch checking is enabled by YSYX_24120013_IMEM_CHECK_EN (see responder).
package ysyx_24120013_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] EBREAK_INST       = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24120013_imem_array.sv
// DEPTH x 32 word store: one synchronous write port (loader), one synchronous
// read port with a held output register; a same-edge write returns the old word.
module ysyx_24120013_imem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_data
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Non-blocking read and write on the same edge give read-before-write ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ysyx_24120013_imem.sv
// Instruction-memory responder: valid/ready fetch request -> LATENCY wait -> word response.
// Define YSYX_24120013_IMEM_CHECK_EN to flag misaligned/out-of-range fetches with ebreak.
module ysyx_24120013_imem_responder
  import ysyx_24120013_imem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic [31:0]     addr_q;
  logic [31:0]     fetch_addr;
  logic [31:0]     off;
  logic            accept;
  logic            fetch;
  logic            bad;
  logic [31:0]     rd_data;

  assign accept = (state == IDLE) && req_valid;
  // The word is read on the edge where the wait count would expire (or at accept when LATENCY is 0).
  assign fetch  = (accept && (LAT == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));

  assign fetch_addr = (state == IDLE) ? req_addr : addr_q;
  assign off        = fetch_addr - BASE_ADDR;

`ifdef YSYX_24120013_IMEM_CHECK_EN
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  logic err_q;

  assign bad       = (off[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
  assign resp_err  = err_q;
  assign resp_inst = err_q ? EBREAK_INST : rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        err_q <= 1'b0;
    else if (fetch) err_q <= bad;
  end
`else
  logic unused_off;

  assign bad        = 1'b0;
  assign resp_err   = 1'b0;
  assign resp_inst  = rd_data;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  ysyx_24120013_imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_en   (fetch && !bad),
    .rd_idx  (off[AW+1:2]),
    .rd_data (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block is given a default first, so no latch can be inferred.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = (LAT == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 4'd0;
      addr_q <= '0;
    end else if (accept) begin
      cnt    <= LAT;
      addr_q <= req_addr;
    end else if (state == WAIT) begin
      cnt    <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_imem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 0, 3) sharing one load port,
// directed table, hand-written corner sequences and randomized fetches against a word model.
module tb_ysyx_24120013_imem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NI    = 3;
`ifdef YSYX_24120013_IMEM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic [31:0] req_addr   [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_inst  [NI];
  logic        resp_err   [NI];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;

  logic [31:0] mem_m [DEPTH];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_24120013_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_24120013_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_24120013_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_inst(resp_inst[2]), .resp_err(resp_err[2]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  typedef struct {
    int          k;
    logic [31:0] addr;
    int          stall;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Word returned for a byte address, straight from the addressing rules.
  function automatic void model(input logic [31:0] addr, output logic [31:0] w, output logic e);
    logic [31:0] off;
    off = addr - BASE;
    if (CHK && (off % 4 != 0 || off >= DEPTH * 4)) begin
      w = 32'h0010_0073;
      e = 1'b1;
    end else begin
      w = mem_m[int'((off / 4) % DEPTH)];
      e = 1'b0;
    end
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = 4'(idx); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mem_m[idx] = d;
  endtask

  // Full transaction on instance k, starting from IDLE; stall = cycles resp_ready stays low in RESP.
  task automatic fetch(input int k, input logic [31:0] addr, input int stall,
                       input logic [31:0] ew, input logic ee, input string tag);
    int          cyc;
    bit          busy_ok;
    bit          stable_ok;
    logic [31:0] held;
    req_valid[k] = 1'b1; req_addr[k] = addr; resp_ready[k] = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_addr[k] = $urandom;
    cyc = 1; busy_ok = 1'b1;
    while (!resp_valid[k] && cyc < 64) begin
      if (req_ready[k]) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (req_ready[k]) busy_ok = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(lat(k) + 1));
    held = resp_inst[k]; stable_ok = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!resp_valid[k] || resp_inst[k] !== held || req_ready[k]) stable_ok = 1'b0;
    end
    check({tag, " inst"}, resp_inst[k], ew);
    check({tag, " err"}, resp_err[k], ee);
    check({tag, " req_ready low while busy"}, busy_ok, 1'b1);
    check({tag, " held during stall"}, stable_ok, 1'b1);
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    check({tag, " idle after handshake"}, {resp_valid[k], req_ready[k]}, 2'b01);
  endtask

  vec_t        tbl [8];
  logic [31:0] ew;
  logic        ee;
  int          w;
  bit          ok;

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; resp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset state inst%0d", k),
            {resp_valid[k], req_ready[k], resp_err[k]}, 3'b010);
      check($sformatf("reset resp_inst inst%0d", k), resp_inst[k], 32'h0);
    end

    for (int i = 0; i < DEPTH; i++) load(i, (i == 3) ? 32'h0000_0513 : 32'hC0DE_0000 + 32'(i));

    tbl[0] = '{0, 32'h8000_000C, 0, 32'h0000_0513, 1'b0};
    tbl[1] = '{1, 32'h8000_0000, 0, 32'hC0DE_0000, 1'b0};
    tbl[2] = '{1, 32'h8000_0004, 2, 32'hC0DE_0001, 1'b0};
    tbl[3] = '{2, 32'h8000_003C, 1, 32'hC0DE_000F, 1'b0};
    tbl[4] = CHK ? '{0, 32'h8000_0040, 0, 32'h0010_0073, 1'b1}
                 : '{0, 32'h8000_0040, 0, 32'hC0DE_0000, 1'b0};
    tbl[5] = CHK ? '{1, 32'h8000_0002, 0, 32'h0010_0073, 1'b1}
                 : '{1, 32'h8000_0002, 0, 32'hC0DE_0000, 1'b0};
    tbl[6] = CHK ? '{2, 32'h7FFF_FFFC, 3, 32'h0010_0073, 1'b1}
                 : '{2, 32'h7FFF_FFFC, 3, 32'hC0DE_000F, 1'b0};
    tbl[7] = '{0, 32'h8000_0024, 4, 32'hC0DE_0009, 1'b0};
    for (int i = 0; i < 8; i++)
      fetch(tbl[i].k, tbl[i].addr, tbl[i].stall, tbl[i].exp_inst, tbl[i].exp_err,
            $sformatf("tbl%0d", i));

    // LATENCY 0 with req_valid held high: no re-accept on the handshake edge.
    req_valid[1] = 1'b1; req_addr[1] = BASE; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("b2b first resp", {resp_valid[1], req_ready[1]}, 2'b10);
    check("b2b first inst", resp_inst[1], 32'hC0DE_0000);
    req_addr[1] = BASE + 32'd4;
    @(posedge clk); #1;
    check("b2b gap after handshake", {resp_valid[1], req_ready[1]}, 2'b01);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("b2b second resp", {resp_valid[1], req_ready[1]}, 2'b10);
    check("b2b second inst", resp_inst[1], 32'hC0DE_0001);
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    check("b2b idle", {resp_valid[1], req_ready[1]}, 2'b01);

    // Stalled response while the same word is rewritten: output holds the old word.
    req_valid[0] = 1'b1; req_addr[0] = BASE + 32'h1C;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    w = 0;
    while (!resp_valid[0] && w < 16) begin @(posedge clk); #1; w++; end
    check("stall resp arrives", resp_valid[0], 1'b1);
    load(7, 32'hDEAD_BEEF);
    ok = 1'b1;
    repeat (4) begin
      if (!resp_valid[0] || resp_inst[0] !== 32'hC0DE_0007) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("stall inst unchanged", resp_inst[0], 32'hC0DE_0007);
    check("stall held every cycle", ok, 1'b1);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    fetch(0, BASE + 32'h1C, 0, 32'hDEAD_BEEF, 1'b0, "rewrite refetch");

    // Write on the very edge the read is registered: old word returned.
    req_valid[0] = 1'b1; req_addr[0] = BASE + 32'h14;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    ld_en = 1'b1; ld_idx = 4'd5; ld_data = 32'h1234_5678;
    @(posedge clk); #1;
    ld_en = 1'b0; mem_m[5] = 32'h1234_5678;
    check("rbw resp valid", resp_valid[0], 1'b1);
    check("rbw old data", resp_inst[0], 32'hC0DE_0005);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    fetch(0, BASE + 32'h14, 0, 32'h1234_5678, 1'b0, "rbw refetch");

    // Asynchronous reset between edges while LATENCY 3 instance is waiting.
    req_valid[2] = 1'b1; req_addr[2] = BASE + 32'h8;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("pre-reset busy", req_ready[2], 1'b0);
    #2 rst = 1'b1;
    #1 check("async reset immediate", {resp_valid[2], req_ready[2]}, 2'b01);
    #1 rst = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid[2] || !req_ready[2]) ok = 1'b0;
    end
    check("no response after reset", ok, 1'b1);
    fetch(2, BASE + 32'h8, 0, 32'hC0DE_0002, 1'b0, "post-reset fetch");

    // Randomized fetches against the word model; loads only between transactions.
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, DEPTH - 1), $urandom);
      a = BASE + 32'($urandom_range(0, 2 * DEPTH - 1)) * 32'd4;
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      model(a, ew, ee);
      fetch(k, a, $urandom_range(0, 3), ew, ee, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
